cpu_if_reg_target: RTL
======================

Name: cpu_if_reg_target

Overview:
- Responder end of the cpu_if request/complete protocol: a memory-mapped register bank in the fast (aclk) domain.
- Accepts single-cycle read/write request pulses, inserts a programmable number of wait states, then returns one access_complete pulse with read data.
- Sits behind the clock-domain bridge on its high-side master port and provides control registers plus a status window to the surrounding datapath.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte base address of the bank; bits [1:0] must be 0.
- NUM_REGS, 16, number of 32-bit word slots; range 3..256.
- WAIT_CYCLES, 2, wait states between request and completion; range 0..15.
- ID_VALUE, 32'hC0DE_0001, constant returned by slot 0.

Ports:
- aclk  in  1  clock
- areset  in  1  reset, synchronous, active-high
- read  in  1  read request pulse, one cycle
- write  in  1  write request pulse, one cycle
- address  in  30  word address, bits [31:2]
- write_data  in  32  write data, valid with write
- access_complete  out  1  completion pulse, one cycle
- read_data  out  32  read result, valid with access_complete, held afterwards
- addr_error  out  1  pulses with access_complete when the address is outside the bank
- proto_error  out  1  sticky; set on a request while busy, or on read and write asserted together
- hw_status  in  32  status word exposed at slot 1
- ctrl_regs  out  (NUM_REGS-2)*32  RW slots 2..NUM_REGS-1, slot 2 in LSBs

Behaviour:
- Reset (areset=1 at a clock edge):
  - FSM goes to IDLE; wait counter = 0.
  - access_complete, addr_error, proto_error = 0.
  - read_data = 0; all ctrl_regs = 0.
  - Reset overrides any in-flight access: no completion pulse is issued, and a pending write is discarded.
- Decode: offset = address - BASE_ADDR[31:2], 30-bit unsigned. In range iff offset < NUM_REGS; wrapped negative offsets are out of range.
- Slot map:
  - Slot 0: ID, read-only, value ID_VALUE.
  - Slot 1: STATUS, read-only, value of hw_status sampled at the completion edge.
  - Slots 2..NUM_REGS-1: RW.
  - Writes to slots 0 and 1 are silently ignored, with no error.
- FSM states: IDLE, WAIT, DONE.
  - IDLE, when read or write is 1:
    - Latch offset, access type, write_data and the range flag.
    - Load wait counter with WAIT_CYCLES.
    - Go to WAIT if WAIT_CYCLES > 0, else to DONE.
  - WAIT: decrement the counter each cycle; when the counter reaches 1, go to DONE on the next edge.
  - DONE (exactly one cycle):
    - access_complete=1.
    - addr_error=1 if out of range.
    - read_data is updated on the edge entering DONE.
    - A write commits to its ctrl_reg on the same edge.
    - Next state is IDLE.
- Latency: request in cycle t gives access_complete in cycle t+1+WAIT_CYCLES. The new ctrl_regs value is visible in that same cycle.
- read_data rules:
  - Read, in range: slot value.
  - Read, out of range: 32'h0.
  - Write: unchanged.
  - read_data holds between completions.
- Out-of-range write: no register changes.
- Busy rule: read or write arriving in WAIT or DONE is dropped (no second completion) and sets proto_error. A new request is accepted again only in IDLE, i.e. the cycle after the DONE cycle at the earliest.
- Simultaneous read and write in IDLE: treated as a write and sets proto_error.
- proto_error clears only on areset.
- At most one access_complete pulse per accepted request; never two consecutive completion cycles.

Test Plan:
- Reset values: assert areset 2 cycles with read=1 → access_complete=0, read_data=0, all ctrl_regs=0, proto_error=0. Release, idle 5 cycles → no completion.
- Write/read slot 2 (WAIT_CYCLES=2, BASE_ADDR=0x4000_0000):
  - write address=0x1000_0002, data 0xA5A5_1234 in cycle t → access_complete in cycle t+3, ctrl_regs[31:0]=0xA5A5_1234 in t+3.
  - read of the same address in cycle t+4 → completion in t+7 with read_data=0xA5A5_1234.
- ID, status and read-only slots:
  - read slot 0 → 0xC0DE_0001.
  - hw_status=0x0000_00F0, read slot 1 → 0x0000_00F0.
  - write 0xFFFF_FFFF to slot 0, then read it → still 0xC0DE_0001; addr_error=0, proto_error=0.
- Out of range: read offset 16 (NUM_REGS=16) and read address BASE-1 → each completes with read_data=0 and addr_error=1. Write offset 16 → ctrl_regs unchanged.
- Busy and illegal requests:
  - read in cycle t, second read in t+1 → one completion only, at t+3; proto_error=1 from t+2.
  - read=write=1 to slot 3, data 0x55 → ctrl slot 3 = 0x55, proto_error=1.
- Reset mid-access and zero wait:
  - write slot 4 data 0x77, areset in t+1 → no completion, slot 4 stays 0.
  - rebuild with WAIT_CYCLES=0: request in cycle t → completion in t+1; back-to-back requests at t and t+2 → completions at t+1 and t+3.

Source files
------------

// File: rtl/cpu_if_reg_target_if.sv
// Request/complete bus between a cpu_if requester and the register bank responder.
interface cpu_if_reg_target_if;
   logic        read;
   logic        write;
   logic [29:0] address;
   logic [31:0] write_data;
   logic        access_complete;
   logic [31:0] read_data;
   logic        addr_error;
   logic        proto_error;

   modport master (
      output read, write, address, write_data,
      input  access_complete, read_data, addr_error, proto_error
   );

   modport slave (
      input  read, write, address, write_data,
      output access_complete, read_data, addr_error, proto_error
   );
endinterface

// File: rtl/cpu_if_reg_target.sv
// Register bank responder for the cpu_if protocol: ID, status window and RW control slots,
// answering each accepted request after WAIT_CYCLES wait states with one completion pulse.
module cpu_if_reg_target #(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          NUM_REGS    = 16,
   parameter int          WAIT_CYCLES = 2,
   parameter logic [31:0] ID_VALUE    = 32'hC0DE_0001
) (
   input  logic                         aclk,
   input  logic                         areset,
   cpu_if_reg_target_if.slave           bus,
   input  logic [31:0]                  hw_status,
   output logic [(NUM_REGS-2)*32-1:0]   ctrl_regs
);
   localparam int         IDX_W     = $clog2(NUM_REGS);
   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

   state_t           state;
   logic [3:0]       wait_cnt;
   logic [IDX_W-1:0] lat_idx;
   logic             lat_wr;
   logic             lat_in_range;
   logic [31:0]      lat_wdata;
   logic [31:0]      ctrl_q [NUM_REGS-2];
   logic [31:0]      read_data_q;
   logic             access_complete_q;
   logic             addr_error_q;
   logic             proto_error_q;

   logic             req;
   logic [29:0]      offset;
   logic             in_range;
   logic             fin;
   logic [IDX_W-1:0] c_idx;
   logic             c_wr;
   logic             c_in_range;
   logic [31:0]      c_wdata;
   logic [31:0]      rd_val;

   assign req      = bus.read | bus.write;
   assign offset   = bus.address - BASE_ADDR[31:2];
   assign in_range = (offset < 30'(NUM_REGS));

   // With zero wait states the access finishes on the accept edge, so it uses the live request
   always_comb begin
      fin        = 1'b0;
      c_idx      = lat_idx;
      c_wr       = lat_wr;
      c_in_range = lat_in_range;
      c_wdata    = lat_wdata;
      if (state == ST_IDLE) begin
         fin        = req && (WAIT_CYCLES == 0);
         c_idx      = offset[IDX_W-1:0];
         c_wr       = bus.write;
         c_in_range = in_range;
         c_wdata    = bus.write_data;
      end else if (state == ST_WAIT) begin
         fin = (wait_cnt == 4'd1);
      end
   end

   always_comb begin
      rd_val = 32'h0;
      if (c_idx == IDX_W'(0))
         rd_val = ID_VALUE;
      else if (c_idx == IDX_W'(1))
         rd_val = hw_status;
      for (int i = 0; i < NUM_REGS - 2; i++)
         if (c_idx == IDX_W'(i + 2))
            rd_val = ctrl_q[i];
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state             <= ST_IDLE;
         wait_cnt          <= 4'd0;
         access_complete_q <= 1'b0;
         addr_error_q      <= 1'b0;
         proto_error_q     <= 1'b0;
         read_data_q       <= 32'h0;
         for (int i = 0; i < NUM_REGS - 2; i++)
            ctrl_q[i] <= 32'h0;
      end else begin
         access_complete_q <= fin;
         addr_error_q      <= fin && !c_in_range;
         if (req && ((state != ST_IDLE) || (bus.read && bus.write)))
            proto_error_q <= 1'b1;

         if (fin) begin
            if (!c_wr)
               read_data_q <= c_in_range ? rd_val : 32'h0;
            else if (c_in_range)
               for (int i = 0; i < NUM_REGS - 2; i++)
                  if (c_idx == IDX_W'(i + 2))
                     ctrl_q[i] <= c_wdata;
         end

         case (state)
            ST_IDLE: begin
               if (req) begin
                  wait_cnt <= WAIT_LOAD;
                  if (WAIT_CYCLES > 0)
                     state <= ST_WAIT;
                  else
                     state <= ST_DONE;
               end
            end
            ST_WAIT: begin
               wait_cnt <= wait_cnt - 4'd1;
               if (wait_cnt == 4'd1)
                  state <= ST_DONE;
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Request capture; only meaningful while an access is in flight, so no reset needed
   always_ff @(posedge aclk) begin
      if (state == ST_IDLE && req) begin
         lat_idx      <= offset[IDX_W-1:0];
         lat_wr       <= bus.write;
         lat_in_range <= in_range;
         lat_wdata    <= bus.write_data;
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_REGS - 2; i++)
         ctrl_regs[i*32 +: 32] = ctrl_q[i];
   end

   assign bus.access_complete = access_complete_q;
   assign bus.read_data       = read_data_q;
   assign bus.addr_error      = addr_error_q;
   assign bus.proto_error     = proto_error_q;
endmodule
